bus_sync_rx: RTL and testbench

// - Destination-side receiver of a multi-bit bus crossing into this CLK domain via 4-phase req/ack.
// - Sits directly downstream of RST_SYNC: RST is that block's SYNC_RST for this domain.
// - bus_req goes through an N-flop synchronizer. unsync_bus is captured once per handshake.
// - Output is a registered bus plus a one-cycle enable_pulse; bus_ack returns to the source domain.
//

---
 rtl/bus_sync_rx_pkg.sv | 14 +
 rtl/bus_sync_rx_if.sv | 27 ++
 rtl/bus_sync_rx_bit_sync.sv | 28 ++
 rtl/bus_sync_rx.sv | 90 +++++++++
 tb/tb_bus_sync_rx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_sync_rx_pkg.sv
// Shared types and defaults for the bus_sync_rx CDC receiver slice.
// Latency: n/a (declarations only).
// Backpressure: n/a; the 4-phase req/ack handshake paces the source.
package bus_sync_rx_pkg;

  localparam int BUS_WIDTH_DEF  = 8;
  localparam int NUM_STAGES_DEF = 2;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } bus_sync_state_e;

endpackage

// File: rtl/bus_sync_rx_if.sv
// Handshake bundle between a 4-phase req/ack source and bus_sync_rx.
// Latency: n/a (wires only).
// Backpressure: the source holds unsync_bus/bus_req until bus_ack answers.
// Signals: unsync_bus/bus_req come from the source domain; sync_bus,
// enable_pulse, bus_ack and busy are driven by the receiver.
interface bus_sync_rx_if
  import bus_sync_rx_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
);
  logic [BUS_WIDTH-1:0] unsync_bus;
  logic                 bus_req;
  logic [BUS_WIDTH-1:0] sync_bus;
  logic                 enable_pulse;
  logic                 bus_ack;
  logic                 busy;

  modport master (
    output unsync_bus, bus_req,
    input  sync_bus, enable_pulse, bus_ack, busy
  );

  modport slave (
    input  unsync_bus, bus_req,
    output sync_bus, enable_pulse, bus_ack, busy
  );
endinterface

// File: rtl/bus_sync_rx_bit_sync.sv
// Single-bit multi-flop synchronizer, reusable by any CDC receiver.
// Latency: NUM_STAGES clock edges from d_i to q_o.
// Backpressure: none; a pure delay line that always accepts.
// Ports: clk_i, rst_ni (async active-low), d_i (async input), q_o (synced).
module bus_sync_rx_bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_STAGES-1:0] stage_q;

  // Plain flop chain: nothing may sit between stages or metastability
  // settling time is eaten by logic delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[NUM_STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync_rx.sv
// Destination side of a 4-phase req/ack bus crossing: captures the bus once per request.
// Latency: NUM_STAGES+1 edges from bus_req rise to sync_bus/enable_pulse/bus_ack.
// Backpressure: bus_ack stays high until req drops; no new capture until ack returns low.
// Ports: CLK, RST (async active-low, from the reset synchronizer), bus (slave modport).
module bus_sync_rx
  import bus_sync_rx_pkg::*;
#(
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF,
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  bus_sync_rx_if.slave  bus
);

  localparam logic [0:0] ST_IDLE     = IDLE;
  localparam logic [0:0] ST_WAIT_LOW = WAIT_LOW;

  if (NUM_STAGES < 2) begin : g_bad_depth
    $error("bus_sync_rx: NUM_STAGES must be >= 2");
  end

  logic                 req_s;
  logic [0:0]           state_q, state_d;
  logic [BUS_WIDTH-1:0] sync_q, sync_d;
  logic                 pulse_q, pulse_d;
  logic                 ack_q, ack_d;
  logic                 busy_q;

  bus_sync_rx_bit_sync #(
    .NUM_STAGES (NUM_STAGES)
  ) u_req_sync (
    .clk_i  (CLK),
    .rst_ni (RST),
    .d_i    (bus.bus_req),
    .q_o    (req_s)
  );

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    pulse_d = 1'b0;
    ack_d   = ack_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          sync_d  = bus.unsync_bus;
          pulse_d = 1'b1;
          ack_d   = 1'b1;
          state_d = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        // Source data may already be changing here; ignore it until req drops.
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sync_d  = '0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
      // Registered from next state so busy tracks state_q cycle-exactly.
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.sync_bus     = sync_q;
  assign bus.enable_pulse = pulse_q;
  assign bus.bus_ack      = ack_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_bus_sync_rx.sv
// Bench for bus_sync_rx: depth-2 and depth-3 receivers driven with identical stimulus.
// Latency: checks NUM_STAGES+1 capture latency and one-edge release.
// Backpressure: source side held until ack; handshake completeness checked.
module tb_bus_sync_rx;
  import bus_sync_rx_pkg::*;

  logic CLK;
  logic RST;

  bus_sync_rx_if #(.BUS_WIDTH(8)) ifc2 ();
  bus_sync_rx_if #(.BUS_WIDTH(8)) ifc3 ();

  bus_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(2)) dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc2)
  );

  bus_sync_rx #(.BUS_WIDTH(8), .NUM_STAGES(3)) dut3 (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: bus_ack is bus_req seen NUM_STAGES+1 edges ago;
  // the pulse marks a rising ack and is where the data gets captured.
  logic [7:0] hist_m  [2];
  logic       ack_m   [2];
  logic       pulse_m [2];
  logic [7:0] sync_m  [2];
  logic       prev_ack[2];
  int         pcnt    [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int d = 0; d < 2; d++) begin
        hist_m[d]  <= '0;
        ack_m[d]   <= 1'b0;
        pulse_m[d] <= 1'b0;
        sync_m[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        hist_m[d]  <= {hist_m[d][6:0], ifc2.bus_req};
        ack_m[d]   <= hist_m[d][depth_of(d)-1];
        pulse_m[d] <= hist_m[d][depth_of(d)-1] & ~ack_m[d];
        if (hist_m[d][depth_of(d)-1] & ~ack_m[d])
          sync_m[d] <= ifc2.unsync_bus;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [7:0] sb, input logic ep,
                         input logic ack, input logic bsy);
    chk($sformatf("model_sync_bus[%0d]", d), {24'b0, sb}, {24'b0, sync_m[d]});
    chk($sformatf("model_pulse[%0d]", d), {31'b0, ep}, {31'b0, pulse_m[d]});
    chk($sformatf("model_ack[%0d]", d), {31'b0, ack}, {31'b0, ack_m[d]});
    chk($sformatf("model_busy[%0d]", d), {31'b0, bsy}, {31'b0, ack_m[d]});
    if (ep) begin
      chk($sformatf("pulse_ack_rise[%0d]", d), {31'b0, ack & ~prev_ack[d]}, 32'd1);
      pcnt[d]++;
    end
    prev_ack[d] = ack;
  endtask

  initial begin
    pcnt[0] = 0; pcnt[1] = 0;
    prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
  end

  always @(posedge CLK) begin
    #1;
    if (cmp_en) begin
      cmp_dut(0, ifc2.sync_bus, ifc2.enable_pulse, ifc2.bus_ack, ifc2.busy);
      cmp_dut(1, ifc3.sync_bus, ifc3.enable_pulse, ifc3.bus_ack, ifc3.busy);
    end
  end

  task automatic drive(input logic [7:0] data, input logic req);
    ifc2.unsync_bus = data; ifc2.bus_req = req;
    ifc3.unsync_bus = data; ifc3.bus_req = req;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [10:0] outs2();
    return {ifc2.sync_bus, ifc2.enable_pulse, ifc2.bus_ack, ifc2.busy};
  endfunction

  function automatic logic [10:0] outs3();
    return {ifc3.sync_bus, ifc3.enable_pulse, ifc3.bus_ack, ifc3.busy};
  endfunction

  int p0, p1;

  initial begin
    RST = 1'b0;
    drive(8'h00, 1'b0);
    tick(3);
    RST = 1'b1;
    cmp_en = 1'b1;

    // Idle after reset release.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_outs2", {21'b0, outs2()}, 32'd0);
      chk("idle_outs3", {21'b0, outs3()}, 32'd0);
    end

    // Basic transfer: req rises before edge 1.
    drive(8'hA5, 1'b1);
    tick(2);
    chk("basic_e2_pulse2", {31'b0, ifc2.enable_pulse}, 32'd0);
    tick(1);
    chk("basic_e3_sync2", {24'b0, ifc2.sync_bus}, 32'hA5);
    chk("basic_e3_pulse2", {31'b0, ifc2.enable_pulse}, 32'd1);
    chk("basic_e3_ack2", {31'b0, ifc2.bus_ack}, 32'd1);
    chk("basic_e3_busy2", {31'b0, ifc2.busy}, 32'd1);
    chk("basic_e3_pulse3", {31'b0, ifc3.enable_pulse}, 32'd0);
    tick(1);
    chk("basic_e4_pulse2", {31'b0, ifc2.enable_pulse}, 32'd0);
    chk("basic_e4_ack2", {31'b0, ifc2.bus_ack}, 32'd1);
    chk("basic_e4_pulse3", {31'b0, ifc3.enable_pulse}, 32'd1);
    chk("basic_e4_sync3", {24'b0, ifc3.sync_bus}, 32'hA5);
    tick(5);
    // Release: drop req before edge 10.
    drive(8'hA5, 1'b0);
    tick(4);
    chk("release_e13_ack2", {31'b0, ifc2.bus_ack}, 32'd0);
    chk("release_e13_busy2", {31'b0, ifc2.busy}, 32'd0);
    chk("release_e13_ack3", {31'b0, ifc3.bus_ack}, 32'd0);
    chk("release_e13_busy3", {31'b0, ifc3.busy}, 32'd0);

    // Second transfer with 8'h3C.
    p0 = pcnt[0];
    drive(8'h3C, 1'b1);
    tick(3);
    chk("second_sync2", {24'b0, ifc2.sync_bus}, 32'h3C);
    chk("second_pulse2", {31'b0, ifc2.enable_pulse}, 32'd1);
    tick(1);
    chk("second_pulse2_off", {31'b0, ifc2.enable_pulse}, 32'd0);
    tick(6);
    drive(8'h3C, 1'b0);
    tick(6);
    chk("second_one_pulse2", pcnt[0] - p0, 32'd1);
    chk("second_ack2_low", {31'b0, ifc2.bus_ack}, 32'd0);

    // Hold: req high ~50 cycles, data changes after capture.
    p0 = pcnt[0]; p1 = pcnt[1];
    drive(8'hA5, 1'b1);
    tick(5);
    drive(8'hFF, 1'b1);
    tick(45);
    chk("hold_sync2", {24'b0, ifc2.sync_bus}, 32'hA5);
    chk("hold_sync3", {24'b0, ifc3.sync_bus}, 32'hA5);
    chk("hold_pulses2", pcnt[0] - p0, 32'd1);
    chk("hold_pulses3", pcnt[1] - p1, 32'd1);
    chk("hold_ack2", {31'b0, ifc2.bus_ack}, 32'd1);
    drive(8'hFF, 1'b0);
    tick(6);

    // Reset mid-transfer with req still high.
    drive(8'hC3, 1'b1);
    tick(6);
    chk("midrst_busy2_before", {31'b0, ifc2.busy}, 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("midrst_outs2", {21'b0, outs2()}, 32'd0);
    chk("midrst_outs3", {21'b0, outs3()}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    prev_ack[0] = 1'b0; prev_ack[1] = 1'b0;
    tick(2);
    chk("midrst_e2_pulse2", {31'b0, ifc2.enable_pulse}, 32'd0);
    chk("midrst_e2_ack2", {31'b0, ifc2.bus_ack}, 32'd0);
    tick(1);
    chk("midrst_e3_pulse2", {31'b0, ifc2.enable_pulse}, 32'd1);
    chk("midrst_e3_sync2", {24'b0, ifc2.sync_bus}, 32'hC3);
    tick(1);
    chk("midrst_e4_pulse3", {31'b0, ifc3.enable_pulse}, 32'd1);
    chk("midrst_e4_sync3", {24'b0, ifc3.sync_bus}, 32'hC3);
    drive(8'hC3, 1'b0);
    tick(6);

    // Depth: NUM_STAGES=3 pulses one edge later than NUM_STAGES=2.
    drive(8'h5A, 1'b1);
    tick(3);
    chk("depth_e3_pulse2", {31'b0, ifc2.enable_pulse}, 32'd1);
    chk("depth_e3_pulse3", {31'b0, ifc3.enable_pulse}, 32'd0);
    tick(1);
    chk("depth_e4_pulse3", {31'b0, ifc3.enable_pulse}, 32'd1);
    chk("depth_e4_sync3", {24'b0, ifc3.sync_bus}, 32'h5A);
    drive(8'h5A, 1'b0);
    tick(6);

    // One-cycle req pulse sampled by a single edge: full handshake follows.
    p0 = pcnt[0]; p1 = pcnt[1];
    drive(8'h77, 1'b1);
    tick(1);
    drive(8'h77, 1'b0);
    tick(10);
    chk("glitch_pulses2", pcnt[0] - p0, 32'd1);
    chk("glitch_pulses3", pcnt[1] - p1, 32'd1);
    chk("glitch_sync2", {24'b0, ifc2.sync_bus}, 32'h77);
    chk("glitch_sync3", {24'b0, ifc3.sync_bus}, 32'h77);
    chk("glitch_ack2", {31'b0, ifc2.bus_ack}, 32'd0);
    chk("glitch_busy3", {31'b0, ifc3.busy}, 32'd0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
